muldiv_iter: RTL and testbench

Iterative multiply/divide unit for the execute stage. Replaces the single-cycle HI/LO multiply path with a parametrised radix-2 shift-add multiplier and restoring divider sharing one datapath. Covers signed and unsigned MULT/DIV. Exposes a start/busy/ready handshake so EX can stall the pipeline, and an annul input so a flushed instruction can abort an operation in flight.

---
 rtl/muldiv_iter_if.sv | 36 +++
 rtl/muldiv_iter.sv | 207 ++++++++++++++++++++
 tb/tb_muldiv_iter.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_iter_if.sv
// muldiv_iter_if: handshake and data bundle between the execute stage and
// the iterative multiply/divide unit.
//   start_i    request a new operation (honoured only while the unit is idle)
//   op_i       00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   opdata1_i  multiplicand / dividend
//   opdata2_i  multiplier / divisor
//   annul_i    abort the operation in flight
//   busy_o     unit not idle; EX stalls on it
//   ready_o    one-cycle completion pulse
//   hi_o/lo_o  MULT: product high/low half; DIV: remainder/quotient
//   dbz_o      divide by zero flag, valid with ready_o
// master = requester (execute stage), slave = muldiv_iter.
interface muldiv_iter_if #(
  parameter int WIDTH = 32
) ();
  logic             start_i;
  logic [1:0]       op_i;
  logic [WIDTH-1:0] opdata1_i;
  logic [WIDTH-1:0] opdata2_i;
  logic             annul_i;
  logic             busy_o;
  logic             ready_o;
  logic [WIDTH-1:0] hi_o;
  logic [WIDTH-1:0] lo_o;
  logic             dbz_o;

  modport master (
    output start_i, op_i, opdata1_i, opdata2_i, annul_i,
    input  busy_o, ready_o, hi_o, lo_o, dbz_o
  );

  modport slave (
    input  start_i, op_i, opdata1_i, opdata2_i, annul_i,
    output busy_o, ready_o, hi_o, lo_o, dbz_o
  );
endinterface

// File: rtl/muldiv_iter.sv
// muldiv_iter: iterative radix-2 shift-add multiplier and restoring divider
// sharing one 2*WIDTH accumulator. Signed and unsigned MULT/DIV.
// Ports:
//   clk   rising-edge clock
//   rst   synchronous active-high reset
//   bus   muldiv_iter_if.slave (start/op/operands/annul in; busy/ready/hi/lo/dbz out)
// Configuration macro MULDIV_DIV_EN: when defined, the divider path, the DIV
// state and divide-by-zero handling are built. When undefined, divide ops
// complete one cycle after acceptance with hi=lo=0 and dbz=0.
// Latency: WIDTH+1 cycles from the accepting edge to ready_o (1 for a
// divide by zero or for divides in the no-divider build). All outputs are
// registered.
module muldiv_iter #(
  parameter int WIDTH = 32
) (
  input logic            clk,
  input logic            rst,
  muldiv_iter_if.slave   bus
);

  localparam int CW = $clog2(WIDTH) + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]         state_reg, state_next;
  logic [CW-1:0]      cnt_reg;
  // MUL: {partial high sum, multiplier being shifted out / product low bits}
  // DIV: {partial remainder, dividend being shifted out / quotient bits}
  logic [2*WIDTH-1:0] acc_reg;
  logic [WIDTH-1:0]   opb_reg;       // multiplicand or divisor magnitude
  logic               neg_res_reg;   // negate product / quotient
  logic               busy_reg, ready_reg, dbz_reg;
  logic [WIDTH-1:0]   hi_reg, lo_reg;

  // Operand decode at the accepting edge.
  logic               start_ok;
  logic               is_div, is_signed, sign1, sign2;
  logic [WIDTH-1:0]   mag1, mag2;
  logic               last_step;

  // Multiply step.
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_acc_next;
  logic [2*WIDTH-1:0] mul_res;

  always_comb begin
    start_ok  = (state_reg == S_IDLE) && bus.start_i && !bus.annul_i;
    is_div    = bus.op_i[1];
    is_signed = !bus.op_i[0];
    sign1     = is_signed && bus.opdata1_i[WIDTH-1];
    sign2     = is_signed && bus.opdata2_i[WIDTH-1];
    mag1      = sign1 ? ({WIDTH{1'b0}} - bus.opdata1_i) : bus.opdata1_i;
    mag2      = sign2 ? ({WIDTH{1'b0}} - bus.opdata2_i) : bus.opdata2_i;
    last_step = (cnt_reg == CW'(WIDTH - 1));
  end

  // Add the multiplicand into the high half when the current multiplier bit
  // is set, then shift the whole accumulator right by one.
  always_comb begin
    mul_sum      = {1'b0, acc_reg[2*WIDTH-1:WIDTH]} +
                   {1'b0, (acc_reg[0] ? opb_reg : {WIDTH{1'b0}})};
    mul_acc_next = {mul_sum, acc_reg[WIDTH-1:1]};
    mul_res      = neg_res_reg ? ({(2*WIDTH){1'b0}} - mul_acc_next) : mul_acc_next;
  end

`ifdef MULDIV_DIV_EN
  logic               neg_rem_reg;   // remainder takes the dividend's sign
  logic [WIDTH:0]     div_shift;
  logic               div_ge;
  logic [WIDTH-1:0]   div_rem_next;
  logic [2*WIDTH-1:0] div_acc_next;
  logic [WIDTH-1:0]   div_quo_res, div_rem_res;

  // Restoring step: bring the next dividend bit into the remainder, subtract
  // the divisor when it fits and record the quotient bit in the low half.
  // The remainder stays below the divisor, so it always fits in WIDTH bits.
  always_comb begin
    div_shift    = {acc_reg[2*WIDTH-1:WIDTH], acc_reg[WIDTH-1]};
    div_ge       = (div_shift >= {1'b0, opb_reg});
    div_rem_next = div_ge ? WIDTH'(div_shift - {1'b0, opb_reg}) : div_shift[WIDTH-1:0];
    div_acc_next = {div_rem_next, acc_reg[WIDTH-2:0], div_ge};
    div_quo_res  = neg_res_reg ? ({WIDTH{1'b0}} - div_acc_next[WIDTH-1:0])
                               : div_acc_next[WIDTH-1:0];
    div_rem_res  = neg_rem_reg ? ({WIDTH{1'b0}} - div_acc_next[2*WIDTH-1:WIDTH])
                               : div_acc_next[2*WIDTH-1:WIDTH];
  end
`endif

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE: begin
        if (start_ok) begin
          if (!is_div) begin
            state_next = S_MUL;
          end else begin
`ifdef MULDIV_DIV_EN
            state_next = (bus.opdata2_i == '0) ? S_DONE : S_DIV;
`else
            state_next = S_DONE;
`endif
          end
        end
      end
      S_MUL: begin
        if (bus.annul_i)     state_next = S_IDLE;
        else if (last_step)  state_next = S_DONE;
      end
`ifdef MULDIV_DIV_EN
      S_DIV: begin
        if (bus.annul_i)     state_next = S_IDLE;
        else if (last_step)  state_next = S_DONE;
      end
`endif
      // DONE always returns to IDLE. The result was presented on entry to
      // DONE, so an annul arriving in DONE has nothing left to cancel.
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= S_IDLE;
      cnt_reg     <= '0;
      acc_reg     <= '0;
      opb_reg     <= '0;
      neg_res_reg <= 1'b0;
`ifdef MULDIV_DIV_EN
      neg_rem_reg <= 1'b0;
`endif
      busy_reg    <= 1'b0;
      ready_reg   <= 1'b0;
      dbz_reg     <= 1'b0;
      hi_reg      <= '0;
      lo_reg      <= '0;
    end else begin
      state_reg <= state_next;
      // Registered from the next state so busy/ready line up with the state.
      busy_reg  <= (state_next != S_IDLE);
      ready_reg <= (state_next == S_DONE);

      case (state_reg)
        S_IDLE: begin
          if (start_ok) begin
            cnt_reg     <= '0;
            neg_res_reg <= sign1 ^ sign2;
            if (is_div) begin
              acc_reg <= {{WIDTH{1'b0}}, mag1};
              opb_reg <= mag2;
`ifdef MULDIV_DIV_EN
              neg_rem_reg <= sign1;
              if (bus.opdata2_i == '0) begin
                // Dividend is reported exactly as supplied, not its magnitude.
                hi_reg  <= bus.opdata1_i;
                lo_reg  <= '1;
                dbz_reg <= 1'b1;
              end
`else
              hi_reg  <= '0;
              lo_reg  <= '0;
              dbz_reg <= 1'b0;
`endif
            end else begin
              acc_reg <= {{WIDTH{1'b0}}, mag2};
              opb_reg <= mag1;
            end
          end
        end
        S_MUL: begin
          if (!bus.annul_i) begin
            acc_reg <= mul_acc_next;
            cnt_reg <= cnt_reg + CW'(1);
            if (last_step) begin
              hi_reg  <= mul_res[2*WIDTH-1:WIDTH];
              lo_reg  <= mul_res[WIDTH-1:0];
              dbz_reg <= 1'b0;
            end
          end
        end
`ifdef MULDIV_DIV_EN
        S_DIV: begin
          if (!bus.annul_i) begin
            acc_reg <= div_acc_next;
            cnt_reg <= cnt_reg + CW'(1);
            if (last_step) begin
              hi_reg  <= div_rem_res;
              lo_reg  <= div_quo_res;
              dbz_reg <= 1'b0;
            end
          end
        end
`endif
        default: ;
      endcase
    end
  end

  assign bus.busy_o  = busy_reg;
  assign bus.ready_o = ready_reg;
  assign bus.hi_o    = hi_reg;
  assign bus.lo_o    = lo_reg;
  assign bus.dbz_o   = dbz_reg;

endmodule

// File: tb/tb_muldiv_iter.sv
// tb_muldiv_iter: randomized and directed self-checking bench for muldiv_iter
// (WIDTH=32). Expected results come from plain 64-bit arithmetic on the
// operands. Honours MULDIV_DIV_EN the same way as the design.
module tb_muldiv_iter;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  muldiv_iter_if #(.WIDTH(W)) bus ();
  muldiv_iter #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0;
  int errors = 0;
  logic [31:0] last_hi = '0;
  logic [31:0] last_lo = '0;
  logic        last_dbz = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic void ref_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] hi, output logic [31:0] lo,
                                 output logic dbz, output int lat);
    longint sa, sb, sp;
    logic [63:0] up;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    hi  = '0;
    lo  = '0;
    dbz = 1'b0;
    lat = W + 1;
    case (op)
      2'b00: begin
        sp = sa * sb;
        up = 64'(sp);
        hi = up[63:32];
        lo = up[31:0];
      end
      2'b01: begin
        up = {32'b0, a} * {32'b0, b};
        hi = up[63:32];
        lo = up[31:0];
      end
      default: begin
`ifdef MULDIV_DIV_EN
        if (b == 32'd0) begin
          lo  = '1;
          hi  = a;
          dbz = 1'b1;
          lat = 1;
        end else if (op == 2'b10) begin
          sp = sa / sb;
          lo = sp[31:0];
          sp = sa % sb;
          hi = sp[31:0];
        end else begin
          lo = a / b;
          hi = a % b;
        end
`else
        lat = 1;
`endif
      end
    endcase
  endfunction

  task automatic scramble_inputs();
    bus.op_i      = 2'($urandom);
    bus.opdata1_i = $urandom;
    bus.opdata2_i = $urandom;
  endtask

  // Issue one operation in IDLE and follow it to completion. With hold set,
  // start_i stays high with changing garbage operands until ready_o, so the
  // unit must ignore starts while busy and in DONE.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input bit hold);
    logic [31:0] ehi, elo;
    logic edbz;
    int elat, lat, busy_low;
    ref_op(op, a, b, ehi, elo, edbz, elat);
    bus.start_i   = 1'b1;
    bus.op_i      = op;
    bus.opdata1_i = a;
    bus.opdata2_i = b;
    @(posedge clk); #1;
    if (hold) scramble_inputs(); else bus.start_i = 1'b0;
    lat = 1;
    busy_low = 0;
    while (!bus.ready_o && lat < 80) begin
      if (!bus.busy_o) busy_low++;
      @(posedge clk); #1;
      if (hold) scramble_inputs();
      lat++;
    end
    if (!bus.busy_o) busy_low++;
    bus.start_i = 1'b0;
    check("latency", 64'(lat), 64'(elat));
    check("busy_during_op", 64'(busy_low), 64'd0);
    check("hi", 64'(bus.hi_o), 64'(ehi));
    check("lo", 64'(bus.lo_o), 64'(elo));
    check("dbz", 64'(bus.dbz_o), 64'(edbz));
    @(posedge clk); #1;
    check("ready_pulse_end", 64'(bus.ready_o), 64'd0);
    check("busy_after_done", 64'(bus.busy_o), 64'd0);
    $display("op=%0d a=%08h b=%08h hold=%0d lat=%0d hi=%08h lo=%08h dbz=%0d",
             op, a, b, hold, lat, bus.hi_o, bus.lo_o, bus.dbz_o);
    last_hi  = ehi;
    last_lo  = elo;
    last_dbz = edbz;
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 9))
      0: return 32'd0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom_range(1, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic ready_seen;
    // start_i held high through reset must not launch anything.
    bus.start_i   = 1'b1;
    bus.op_i      = 2'b01;
    bus.opdata1_i = 32'd3;
    bus.opdata2_i = 32'd4;
    bus.annul_i   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 64'(bus.busy_o), 64'd0);
    check("rst_ready", 64'(bus.ready_o), 64'd0);
    check("rst_dbz", 64'(bus.dbz_o), 64'd0);
    check("rst_hi", 64'(bus.hi_o), 64'd0);
    check("rst_lo", 64'(bus.lo_o), 64'd0);
    rst = 1'b0;
    bus.start_i = 1'b0;
    @(posedge clk); #1;
    check("idle_after_rst", 64'(bus.busy_o), 64'd0);

    // Directed cases.
    run_op(2'b00, 32'hFFFF_FFFD, 32'h0000_0005, 1'b0);
    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    run_op(2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 1'b0);
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    run_op(2'b11, 32'd100, 32'd0, 1'b1);
    run_op(2'b00, 32'h8000_0000, 32'h8000_0000, 1'b0);
    run_op(2'b10, 32'h0000_0007, 32'hFFFF_FFFE, 1'b0);

    // Annul a MULT at cycle 10; previous result must survive.
    bus.start_i   = 1'b1;
    bus.op_i      = 2'b00;
    bus.opdata1_i = 32'h1234_5678;
    bus.opdata2_i = 32'h0000_0099;
    @(posedge clk); #1;
    bus.start_i = 1'b0;
    ready_seen = bus.ready_o;
    repeat (9) begin
      @(posedge clk); #1;
      ready_seen |= bus.ready_o;
    end
    bus.annul_i = 1'b1;
    @(posedge clk); #1;
    bus.annul_i = 1'b0;
    ready_seen |= bus.ready_o;
    check("annul_busy", 64'(bus.busy_o), 64'd0);
    check("annul_no_ready", 64'(ready_seen), 64'd0);
    check("annul_hi", 64'(bus.hi_o), 64'(last_hi));
    check("annul_lo", 64'(bus.lo_o), 64'(last_lo));
    $display("annul after 10 cycles busy=%0d hi=%08h lo=%08h", bus.busy_o, bus.hi_o, bus.lo_o);
    run_op(2'b01, 32'd3, 32'd4, 1'b0);

    // annul together with start in IDLE: no start.
    bus.start_i = 1'b1;
    bus.annul_i = 1'b1;
    bus.op_i    = 2'b00;
    @(posedge clk); #1;
    bus.start_i = 1'b0;
    bus.annul_i = 1'b0;
    check("annul_start_busy", 64'(bus.busy_o), 64'd0);
    $display("annul+start in IDLE busy=%0d", bus.busy_o);

    // Randomized operations with idle gaps checking that results hold.
    for (int i = 0; i < 40; i++) begin
      run_op(2'($urandom), pick_operand(), pick_operand(), 1'($urandom));
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #0;
      check("hold_hi", 64'(bus.hi_o), 64'(last_hi));
      check("hold_lo", 64'(bus.lo_o), 64'(last_lo));
      check("hold_dbz", 64'(bus.dbz_o), 64'(last_dbz));
    end

    // Reset in cycle 5 of a DIV, with start_i held during reset.
    run_op(2'b01, 32'd9, 32'd9, 1'b0);
    bus.start_i   = 1'b1;
    bus.op_i      = 2'b10;
    bus.opdata1_i = 32'd1000;
    bus.opdata2_i = 32'd7;
    @(posedge clk); #1;
    bus.start_i = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    bus.start_i = 1'b1;
    @(posedge clk); #1;
    check("midrst_busy", 64'(bus.busy_o), 64'd0);
    check("midrst_ready", 64'(bus.ready_o), 64'd0);
    check("midrst_dbz", 64'(bus.dbz_o), 64'd0);
    check("midrst_hi", 64'(bus.hi_o), 64'd0);
    check("midrst_lo", 64'(bus.lo_o), 64'd0);
    $display("reset during DIV busy=%0d hi=%08h lo=%08h", bus.busy_o, bus.hi_o, bus.lo_o);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    bus.start_i = 1'b0;
    @(posedge clk); #1;
    check("post_rst_idle", 64'(bus.busy_o), 64'd0);
    run_op(2'b11, 32'd1000, 32'd7, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
